// File: rtl/platform_player_fsm.sv
`default_nettype none
// ============================================================================
// Module   : platform_player_fsm
// Purpose  : Per-frame player motion (RUN/JUMP/FALL) with block collisions;
//            PLAYER_VAR_JUMP_EN enables early jump release.
// Revision : 1.0 - initial release
// ============================================================================
module platform_player_fsm #(
   parameter int N_BLOCKS        = 8,
   parameter int PLAYER_S        = 30,
   parameter int BLOCK_W         = 28,
   parameter int BLOCK_H         = 28,
   parameter int GROUND_Y        = 344,
   parameter int PAGE_W          = 640,
   parameter int JUMP_FRAMES     = 35,
   parameter int VY              = 2,
   parameter int RUN_STEP        = 2,
   parameter int SPRINT_STEP     = 4,
   parameter int MIN_JUMP_FRAMES = 8
) (
   input  logic                     frame_clk,
   input  logic                     reset,
   input  logic [7:0]               keycode,
   input  logic                     sprint,
   input  logic                     restart,
   input  logic [10*N_BLOCKS-1:0]   block_x,
   input  logic [10*N_BLOCKS-1:0]   block_y,
   input  logic [N_BLOCKS-1:0]      block_en,
   output logic signed [31:0]       world_x,
   output logic [9:0]               x_offset,
   output logic [9:0]               player_y,
   output logic [15:0]              page_index,
   output logic [N_BLOCKS-1:0]      hit_flags,
   output logic [1:0]               state,
   output logic                     hit_pulse
);
   typedef enum logic [1:0] {ST_RUN = 2'b00, ST_JUMP = 2'b01, ST_FALL = 2'b10} state_t;

   localparam logic [7:0] c_KEY_LEFT  = 8'h04;
   localparam logic [7:0] c_KEY_RIGHT = 8'h07;
   localparam logic [7:0] c_KEY_JUMP  = 8'h1A;
   localparam int c_CNT_MAX = (JUMP_FRAMES > MIN_JUMP_FRAMES) ? JUMP_FRAMES : MIN_JUMP_FRAMES;
   localparam int c_CNT_W   = $clog2(c_CNT_MAX + 1);
   localparam logic [10:0] c_S      = 11'(PLAYER_S);
   localparam logic [10:0] c_BW     = 11'(BLOCK_W);
   localparam logic [10:0] c_BH     = 11'(BLOCK_H);
   localparam logic [10:0] c_GROUND = 11'(GROUND_Y);
   localparam logic [10:0] c_VY     = 11'(VY);
   localparam logic signed [12:0] c_S13      = 13'(PLAYER_S);
   localparam logic signed [12:0] c_BW13     = 13'(BLOCK_W);
   localparam logic signed [12:0] c_PAGE13   = 13'(PAGE_W);
   localparam logic signed [12:0] c_RUN13    = 13'(RUN_STEP);
   localparam logic signed [12:0] c_SPRINT13 = 13'(SPRINT_STEP);

   logic signed [31:0]   wx_q, wx_d;
   logic [9:0]           xoff_q, xoff_d, py_q, py_d;
   logic [15:0]          page_q, page_d;
   state_t               st_q, st_d;
   logic [c_CNT_W-1:0]   cnt_q, cnt_d, w_cnt_inc;
   logic [N_BLOCKS-1:0]  flags_q, flags_d;
   logic                 pulse_q, pulse_d;

   logic signed [12:0]   w_step, w_dx, w_dx_eff, w_px, w_cand, w_xoff_sum;
   logic signed [31:0]   w_wx_sum;
   logic [10:0]          w_px11, w_py, w_bump_y, w_land_y, w_tgt;
   logic [N_BLOCKS-1:0]  w_hov, w_blk, w_sup, w_bump, w_land;

   assign w_px11     = {1'b0, xoff_q};
   assign w_py       = {1'b0, py_q};
   assign w_px       = $signed({3'b000, xoff_q});
   assign w_step     = sprint ? c_SPRINT13 : c_RUN13;
   assign w_dx       = (keycode == c_KEY_LEFT)  ? -w_step :
                       (keycode == c_KEY_RIGHT) ?  w_step : 13'sd0;
   assign w_cand     = w_px + w_dx;
   assign w_dx_eff   = (|w_blk) ? 13'sd0 : w_dx;
   assign w_wx_sum   = wx_q + $signed({{19{w_dx_eff[12]}}, w_dx_eff});
   assign w_xoff_sum = w_px + w_dx_eff;
   assign w_cnt_inc  = cnt_q + 1'b1;

   for (genvar gi = 0; gi < N_BLOCKS; gi++) begin : g_blk
      logic [10:0]        bx, by;
      logic signed [12:0] bxs;
      logic               vov;
      assign bx  = {1'b0, block_x[10*gi +: 10]};
      assign by  = {1'b0, block_y[10*gi +: 10]};
      assign bxs = $signed({3'b000, block_x[10*gi +: 10]});
      assign vov = (w_py + c_S > by) && (w_py < by + c_BH);
      assign w_hov[gi]  = block_en[gi] && (w_px11 + c_S > bx) && (w_px11 < bx + c_BW);
      assign w_blk[gi]  = block_en[gi] && vov && (w_cand + c_S13 > bxs) && (w_cand < bxs + c_BW13);
      assign w_sup[gi]  = w_hov[gi] && (w_py + c_S == by);
      assign w_bump[gi] = w_hov[gi] && (w_py <= by + c_BH + c_VY) && (w_py >= by + c_BH);
      assign w_land[gi] = w_hov[gi] && (w_py + c_S <= by) && (w_py + c_VY + c_S >= by);
   end

   always_comb begin
      wx_d = wx_q;  xoff_d = xoff_q;  page_d = page_q;  py_d = py_q;
      st_d = st_q;  cnt_d = cnt_q;    flags_d = flags_q; pulse_d = 1'b0;
      w_bump_y = 11'd0;
      w_land_y = 11'h7FF;
      w_tgt    = 11'h7FF;

      // Nearest contact wins: lowest block bottom when rising, highest top when falling
      for (int i = 0; i < N_BLOCKS; i++) begin
         if (w_bump[i] && ({1'b0, block_y[10*i +: 10]} + c_BH > w_bump_y))
            w_bump_y = {1'b0, block_y[10*i +: 10]} + c_BH;
         if (w_land[i] && ({1'b0, block_y[10*i +: 10]} - c_S < w_land_y))
            w_land_y = {1'b0, block_y[10*i +: 10]} - c_S;
      end

      if (w_wx_sum[31]) begin
         wx_d = '0;  xoff_d = '0;  page_d = '0;
      end else begin
         wx_d = w_wx_sum;
         if (w_xoff_sum >= c_PAGE13) begin
            xoff_d = 10'(w_xoff_sum - c_PAGE13);
            page_d = page_q + 16'd1;
         end else if (w_xoff_sum < 13'sd0) begin
            xoff_d = 10'(w_xoff_sum + c_PAGE13);
            page_d = page_q - 16'd1;
         end else begin
            xoff_d = 10'(w_xoff_sum);
         end
      end

      case (st_q)
         ST_RUN: begin
            cnt_d = '0;
            if (keycode == c_KEY_JUMP)
               st_d = ST_JUMP;
            else if ((w_py != c_GROUND) && !(|w_sup))
               st_d = ST_FALL;
         end
         ST_JUMP: begin
            cnt_d = w_cnt_inc;
            if (|w_bump) begin
               py_d    = 10'(w_bump_y);
               flags_d = flags_q | w_bump;
               pulse_d = |(w_bump & ~flags_q);
               st_d    = ST_FALL;
            end
`ifdef PLAYER_VAR_JUMP_EN
            else if ((cnt_q >= c_CNT_W'(MIN_JUMP_FRAMES)) && (keycode != c_KEY_JUMP)) begin
               cnt_d = cnt_q;
               st_d  = ST_FALL;
            end
`endif
            else if (w_py < c_VY) begin
               py_d = '0;
               st_d = ST_FALL;
            end else begin
               py_d = 10'(w_py - c_VY);
               if (w_cnt_inc == c_CNT_W'(JUMP_FRAMES))
                  st_d = ST_FALL;
            end
         end
         ST_FALL: begin
            if (w_py + c_VY >= c_GROUND)
               w_tgt = c_GROUND;
            if ((|w_land) && (w_land_y < w_tgt))
               w_tgt = w_land_y;
            if (w_tgt != 11'h7FF) begin
               py_d  = 10'(w_tgt);
               st_d  = ST_RUN;
               cnt_d = '0;
            end else begin
               py_d = 10'(w_py + c_VY);
            end
         end
         default: st_d = ST_RUN;
      endcase

      // A page turn invalidates every sticky flag, including ones hit this frame
      if (page_d != page_q) begin
         flags_d = '0;
         pulse_d = 1'b0;
      end

      if (restart) begin
         wx_d = '0;  xoff_d = '0;  page_d = '0;  py_d = 10'(GROUND_Y);
         st_d = ST_RUN;  cnt_d = '0;  flags_d = '0;  pulse_d = 1'b0;
      end
   end

   always_ff @(posedge frame_clk) begin
      if (reset) begin
         wx_q    <= '0;
         xoff_q  <= '0;
         page_q  <= '0;
         py_q    <= 10'(GROUND_Y);
         st_q    <= ST_RUN;
         cnt_q   <= '0;
         flags_q <= '0;
         pulse_q <= 1'b0;
      end else begin
         wx_q    <= wx_d;
         xoff_q  <= xoff_d;
         page_q  <= page_d;
         py_q    <= py_d;
         st_q    <= st_d;
         cnt_q   <= cnt_d;
         flags_q <= flags_d;
         pulse_q <= pulse_d;
      end
   end

   assign world_x    = wx_q;
   assign x_offset   = xoff_q;
   assign page_index = page_q;
   assign player_y   = py_q;
   assign state      = st_q;
   assign hit_flags  = flags_q;
   assign hit_pulse  = pulse_q;
endmodule
`default_nettype wire

// File: tb/tb_platform_player_fsm.sv
`default_nettype none
// ============================================================================
// Module   : tb_platform_player_fsm
// Purpose  : Self-checking bench for platform_player_fsm (default build).
// Revision : 1.0 - initial release
// ============================================================================
module tb_platform_player_fsm;
   localparam int NB = 8;
   localparam int RUN = 0, JUMP = 1, FALL = 2;

   logic                frame_clk = 1'b0;
   logic                reset, sprint, restart;
   logic [7:0]          keycode;
   logic [10*NB-1:0]    block_x, block_y;
   logic [NB-1:0]       block_en;
   logic signed [31:0]  world_x;
   logic [9:0]          x_offset, player_y;
   logic [15:0]         page_index;
   logic [NB-1:0]       hit_flags;
   logic [1:0]          state;
   logic                hit_pulse;

   platform_player_fsm dut (
      .frame_clk (frame_clk), .reset (reset), .keycode (keycode), .sprint (sprint),
      .restart (restart), .block_x (block_x), .block_y (block_y), .block_en (block_en),
      .world_x (world_x), .x_offset (x_offset), .player_y (player_y),
      .page_index (page_index), .hit_flags (hit_flags), .state (state),
      .hit_pulse (hit_pulse)
   );

   always #5 frame_clk = ~frame_clk;

   typedef struct {
      bit valid;
      int wx;
      int y;
      int st;
      int fl;
      int pu;
   } exp_t;

   typedef struct {
      logic [7:0] kc;
      bit         sp;
      bit         rs;
      int         reps;
      int         wx;
   } row_t;

   exp_t sbq[$];
   exp_t e;
   row_t tbl[8];
   int   errors = 0;
   int   checks = 0;
   int   ef;

   task automatic cmp(input string nm, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
      end
   endtask

   // Outputs of each edge are compared 1 time unit later against the queued expectation
   always @(posedge frame_clk) begin
      #1;
      if (sbq.size() > 0) begin
         e = sbq.pop_front();
         if (e.valid) begin
            cmp("world_x",    int'(world_x),  e.wx);
            cmp("x_offset",   int'(x_offset), e.wx % 640);
            cmp("page_index", int'(page_index), e.wx / 640);
            cmp("player_y",   int'(player_y), e.y);
            cmp("state",      int'(state),    e.st);
            cmp("hit_flags",  int'(hit_flags), e.fl);
            cmp("hit_pulse",  int'(hit_pulse), e.pu);
         end
      end
   end

   task automatic step(input logic [7:0] kc, input bit sp, input bit rs, input bit rt,
                       input bit chk, input int wx, input int y, input int st,
                       input int fl, input int pu);
      @(negedge frame_clk);
      keycode = kc;  sprint = sp;  restart = rs;  reset = rt;
      sbq.push_back(exp_t'{chk, wx, y, st, fl, pu});
   endtask

   initial begin
      reset = 1'b1;  restart = 1'b0;  keycode = 8'h00;  sprint = 1'b0;
      block_x = '0;  block_y = '0;  block_en = '0;

      tbl[0] = '{8'h07, 1'b0, 1'b0, 10, 20};
      tbl[1] = '{8'h07, 1'b1, 1'b0,  5, 40};
      tbl[2] = '{8'h04, 1'b0, 1'b0,  3, 34};
      tbl[3] = '{8'h04, 1'b1, 1'b0, 10,  0};
      tbl[4] = '{8'h55, 1'b0, 1'b0,  2,  0};
      tbl[5] = '{8'h07, 1'b1, 1'b0,  1,  4};
      tbl[6] = '{8'h07, 1'b0, 1'b0,  1,  6};
      tbl[7] = '{8'h07, 1'b0, 1'b1,  1,  0};

      step(8'h00, 0, 0, 1, 1, 0, 344, RUN, 0, 0);
      step(8'h07, 0, 0, 1, 1, 0, 344, RUN, 0, 0);

      foreach (tbl[r])
         for (int n = 0; n < tbl[r].reps; n++)
            step(tbl[r].kc, tbl[r].sp, tbl[r].rs, 0, n == tbl[r].reps - 1,
                 tbl[r].wx, 344, RUN, 0, 0);

      // Full-height jump and descent with no blocks
      step(8'h1A, 0, 0, 0, 1, 0, 344, JUMP, 0, 0);
      for (int k = 1; k <= 35; k++) step(8'h00, 0, 0, 0, 1, 0, 344 - 2*k, (k == 35) ? FALL : JUMP, 0, 0);
      for (int m = 1; m <= 35; m++) step(8'h00, 0, 0, 0, 1, 0, 274 + 2*m, (m == 35) ? RUN : FALL, 0, 0);

      // Head-bump under block0 (bottom edge 278), twice: pulse only on the first
      block_x[9:0] = 10'd320;  block_y[9:0] = 10'd250;  block_en[0] = 1'b1;
      for (int j = 1; j <= 155; j++) step(8'h07, 0, 0, 0, j == 155, 2*j, 344, RUN, 0, 0);
      ef = 0;
      for (int rep = 0; rep < 2; rep++) begin
         step(8'h1A, 0, 0, 0, 1, 310, 344, JUMP, ef, 0);
         for (int k = 1; k <= 32; k++) step(8'h00, 0, 0, 0, 1, 310, 344 - 2*k, JUMP, ef, 0);
         step(8'h00, 0, 0, 0, 1, 310, 278, FALL, 1, (rep == 0) ? 1 : 0);
         ef = 1;
         for (int m = 1; m <= 33; m++) step(8'h00, 0, 0, 0, 1, 310, 278 + 2*m, (m == 33) ? RUN : FALL, 1, 0);
      end

      // Page turn at 640 clears flags; stepping back turns the page down again
      for (int j = 1; j <= 165; j++) step(8'h07, 0, 0, 0, 1, 310 + 2*j, 344, RUN, (j < 165) ? 1 : 0, 0);
      step(8'h04, 0, 0, 0, 1, 638, 344, RUN, 0, 0);

      // Horizontal block: block1 at x 320, top 330 overlaps the standing player
      step(8'h00, 0, 1, 0, 1, 0, 344, RUN, 0, 0);
      block_en = '0;
      block_x[19:10] = 10'd320;  block_y[19:10] = 10'd330;  block_en[1] = 1'b1;
      for (int j = 1; j <= 150; j++) step(8'h07, 0, 0, 0, 1, (2*j < 290) ? 2*j : 290, 344, RUN, 0, 0);
      step(8'h07, 1, 0, 0, 1, 290, 344, RUN, 0, 0);
      step(8'h04, 0, 0, 0, 1, 288, 344, RUN, 0, 0);
      step(8'h07, 0, 0, 0, 1, 290, 344, RUN, 0, 0);

      // Jump over the block edge, land on its top, then walk off the far side
      step(8'h1A, 0, 0, 0, 1, 290, 344, JUMP, 0, 0);
      for (int k = 1; k <= 35; k++)
         step(8'h07, 0, 0, 0, 1, (k <= 22) ? 290 : 290 + 2*(k - 22), 344 - 2*k, (k == 35) ? FALL : JUMP, 0, 0);
      for (int m = 1; m <= 13; m++) step(8'h00, 0, 0, 0, 1, 316, 274 + 2*m, (m == 13) ? RUN : FALL, 0, 0);
      for (int j = 1; j <= 17; j++) step(8'h07, 0, 0, 0, 1, 316 + 2*j, 300, (j == 17) ? FALL : RUN, 0, 0);
      for (int m = 1; m <= 22; m++) step(8'h00, 0, 0, 0, 1, 350, 300 + 2*m, (m == 22) ? RUN : FALL, 0, 0);

      // Restart mid-jump, then reset mid-walk
      step(8'h1A, 0, 0, 0, 1, 350, 344, JUMP, 0, 0);
      for (int k = 1; k <= 5; k++) step(8'h00, 0, 0, 0, 1, 350, 344 - 2*k, JUMP, 0, 0);
      step(8'h00, 0, 1, 0, 1, 0, 344, RUN, 0, 0);
      step(8'h07, 0, 0, 0, 1, 2, 344, RUN, 0, 0);
      step(8'h07, 0, 0, 0, 1, 4, 344, RUN, 0, 0);
      step(8'h07, 0, 0, 1, 1, 0, 344, RUN, 0, 0);
      step(8'h00, 0, 0, 0, 1, 0, 344, RUN, 0, 0);

      @(negedge frame_clk);
      @(negedge frame_clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire
